// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states, forwarding selects, counter width and register-match helper
package hazard_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_BAD   = 2'b11
  } state_e;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam int STALL_CNT_W = 16;
  // A writer only matters when it really writes a non-zero register the reader uses
  function automatic logic reg_match(input logic [4:0] dst, input logic we, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rt);
    return we && (dst != 5'd0) && (dst == rs || (use_rt && dst == rt));
  endfunction
endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: ALU operand forwarding selects, MEM result preferred over WB data
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] write_reg_mem,
  input  logic       regwrite_mem,
  input  logic [4:0] write_reg_wb,
  input  logic       regwrite_wb,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  // Youngest producer wins; register 0 is never forwarded
  always_comb begin
    fwd_a = reg_match(write_reg_mem, regwrite_mem, rs_ex, 5'd0, 1'b0) ? FWD_MEM :
            reg_match(write_reg_wb, regwrite_wb, rs_ex, 5'd0, 1'b0) ? FWD_WB : FWD_REG;
    fwd_b = reg_match(write_reg_mem, regwrite_mem, rt_ex, 5'd0, 1'b0) ? FWD_MEM :
            reg_match(write_reg_wb, regwrite_wb, rt_ex, 5'd0, 1'b0) ? FWD_WB : FWD_REG;
  end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/forward control; HAZARD_FORWARDING_EN enables forwarding
module hazard_controller
  import hazard_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             rs_id,
  input  logic [4:0]             rt_id,
  input  logic                   uses_rt_id,
  input  logic [4:0]             rs_ex,
  input  logic [4:0]             rt_ex,
  input  logic [4:0]             write_reg_ex,
  input  logic                   regwrite_ex,
  input  logic                   memread_ex,
  input  logic [4:0]             write_reg_mem,
  input  logic                   regwrite_mem,
  input  logic [4:0]             write_reg_wb,
  input  logic                   regwrite_wb,
  input  logic                   branch_taken_mem,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);
  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   hz, br;
  logic                   ex_hit;
  assign ex_hit = reg_match(write_reg_ex, regwrite_ex, rs_id, rt_id, uses_rt_id);
`ifdef HAZARD_FORWARDING_EN
  logic [1:0] fa, fb;
  hazard_fwd_unit u_fwd (
    .rs_ex        (rs_ex),
    .rt_ex        (rt_ex),
    .write_reg_mem(write_reg_mem),
    .regwrite_mem (regwrite_mem),
    .write_reg_wb (write_reg_wb),
    .regwrite_wb  (regwrite_wb),
    .fwd_a        (fa),
    .fwd_b        (fb)
  );
  assign hz    = memread_ex && ex_hit;
  assign fwd_a = rst_n ? fa : FWD_REG;
  assign fwd_b = rst_n ? fb : FWD_REG;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs_ex, rt_ex, memread_ex};
  assign hz    = ex_hit ||
                 reg_match(write_reg_mem, regwrite_mem, rs_id, rt_id, uses_rt_id) ||
                 reg_match(write_reg_wb, regwrite_wb, rs_id, rt_id, uses_rt_id);
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
`endif
  assign state       = state_q;
  assign stall_count = stall_count_q;
  // Same-cycle stall/flush decisions; a taken branch beats a stall, FLUSH ignores hazards, reset forces idle values
  always_comb begin
    br            = rst_n && branch_taken_mem;
    id_ex_bubble  = rst_n && !br && hz && (state_q == ST_RUN || state_q == ST_STALL);
    pc_write      = !id_ex_bubble;
    if_id_write   = !id_ex_bubble;
    if_id_flush   = br;
    id_ex_flush   = br;
    ex_mem_flush  = br;
    state_d       = state_q == ST_BAD ? ST_RUN : br ? ST_FLUSH : id_ex_bubble ? ST_STALL : ST_RUN;
    stall_count_d = (id_ex_bubble && stall_count_q != '1) ? stall_count_q + STALL_CNT_W'(1) : stall_count_q;
  end
  // State and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 rs_id, rt_id  in  5 each  source register fields of the instruction in ID (bits 25:21, 20:16).
REQ-005 uses_rt_id  in  1  ID instruction reads rt as an operand (R-type, store, branch).
REQ-006 rs_ex, rt_ex  in  5 each  source register fields of the instruction in EX.
REQ-007 write_reg_ex / regwrite_ex / memread_ex  in  5/1/1  EX destination, register-write enable and load flag.
REQ-008 write_reg_mem / regwrite_mem  in  5/1  MEM destination and register-write enable.
REQ-009 write_reg_wb / regwrite_wb  in  5/1  WB destination and register-write enable.
REQ-010 branch_taken_mem  in  1  Zero_MEM AND Branch_MEM.
REQ-011 pc_write, if_id_write  out  1 each  PC and IF_ID load enables; 0 holds the register.
REQ-012 id_ex_bubble  out  1  forces ID_EX control fields to zero.
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the stage register to a NOP.
REQ-014 fwd_a, fwd_b  out  2 each  ALU operand source select: 00 register file, 10 MEM ALU result, 01 WB write data.
REQ-015 state  out  2  current FSM state, for debug.
REQ-016 stall_count  out  16  total stalled cycles since reset.

Function
REQ-017 FSM states: RUN=00, STALL=01, FLUSH=10; 11 is unreachable and SHALL recover to RUN on the next edge.
REQ-018 A register match SHALL count only when the destination is non-zero, the stage's regwrite is 1, and the destination equals rs_id, or equals rt_id with uses_rt_id=1.
REQ-019 A hazard SHALL be detected combinationally in the same cycle as its inputs.
REQ-020 On a hazard: pc_write=0, if_id_write=0, id_ex_bubble=1, and the next state is STALL.
REQ-021 STALL SHALL persist while the hazard persists and return to RUN on the first cycle with no hazard.
REQ-022 If branch_taken_mem=1, the block SHALL drive if_id_flush=id_ex_flush=ex_mem_flush=1 and pc_write=1 in that cycle, and the next state SHALL be FLUSH.
REQ-023 A taken branch SHALL take priority over any stall in the same cycle; id_ex_bubble SHALL be 0 in that cycle.
REQ-024 FLUSH SHALL last exactly one cycle, suppress hazard detection, then go to RUN.
REQ-025 A taken branch arriving while in FLUSH SHALL be honoured again.
REQ-026 stall_count SHALL increment on every cycle with id_ex_bubble=1 and saturate at 16'hFFFF.

Reset
REQ-027 While rst_n=0: state=RUN, stall_count=0, pc_write=1, if_id_write=1, all flush and bubble outputs 0, fwd_a=fwd_b=00.
REQ-028 A reset asserted mid-STALL or mid-FLUSH SHALL return the block to these values immediately, independent of clk.

Configuration
REQ-029 Macro HAZARD_FORWARDING_EN defined: the block SHALL compute fwd_a/fwd_b from rs_ex/rt_ex, with MEM matches taking priority over WB matches and register 0 never forwarded.
REQ-030 With HAZARD_FORWARDING_EN defined, a hazard SHALL mean only a load-use hazard: memread_ex=1 and an EX match.
REQ-031 Macro undefined: fwd_a=fwd_b=00 constantly, and a hazard SHALL mean any match in the EX, MEM or WB stage.

Structure
REQ-032 Package hazard_pkg SHALL hold the FSM state encodings, the fwd select encodings and the stall counter width.
REQ-033 Forwarding comparison SHALL be a sub-module hazard_fwd_unit, instantiated only under HAZARD_FORWARDING_EN.

Verification
REQ-034 Forwarding on, EX lw writing $8, ID add $9,$8,$10 -> one cycle pc_write=0, id_ex_bubble=1, state 01; then RUN; stall_count=1.
REQ-035 Forwarding on, MEM and WB both write $8, EX rs=$8 -> fwd_a=10; with the MEM write removed -> fwd_a=01; with rs=$0 -> fwd_a=00.
REQ-036 Forwarding off, add $8 followed by sub using $8 -> 3 stall cycles; stall_count=3.
REQ-037 branch_taken_mem=1 together with a load-use hazard -> all three flushes=1, pc_write=1, id_ex_bubble=0, then state 10 for one cycle, then 00.
REQ-038 rst_n pulsed low mid-STALL between clock edges -> outputs return to reset values immediately; stall_count=0.
REQ-039 Force 70000 hazard cycles -> stall_count holds at 16'hFFFF.
